rca64_share_ctrl: RTL and testbench

- Round-robin controller that shares one 64-bit ripple-carry adder datapath (RCA64-style: operands in; sum and carry-out back) between NREQ requesters.
- Sits between client blocks and the single adder instance.
- Each transaction:
  1. Arbitrate among valid requesters.
  2. Latch the winner's operands into the adder-driving registers.
  3. Wait out the adder latency.
  4. Capture sum and carry-out.
  5. Return them tagged with the requester id over a valid/ready response channel.
- One transaction in flight at a time; no pipelining.

---
 rtl/rca_ctrl_pkg.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/rca64_share_ctrl.sv | 121 ++++++++++++
 tb/tb_rca64_share_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_ctrl_pkg.sv
// Shared types and helpers for the round-robin adder-sharing controller.
// Holds the FSM state encoding, the default operand width and a wrap-around increment.
package rca_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 64;

  // Next requester index after id, wrapping to 0 at n.
  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: the first asserted request found
// scanning from i_ptr upward, modulo NREQ, wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);

  logic [ID_W-1:0] w_idx;

  // NOTE: every output gets a default before the loop so no path can infer a latch.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end

endmodule

// File: rtl/rca64_share_ctrl.sv
// Round-robin controller sharing one external adder between NREQ requesters.
// One transaction in flight: grant, drive operands, wait ADD_LAT, capture, respond.
module rca64_share_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADD_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_op1,
  input  logic [NREQ*DATA_W-1:0] req_op2,
  output logic [NREQ-1:0]        req_ready,
  output logic [DATA_W-1:0]      add_op1,
  output logic [DATA_W-1:0]      add_op2,
  input  logic [DATA_W-1:0]      add_sum,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int CNT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_add_op1;
  logic [DATA_W-1:0]  r_add_op2;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [DATA_W-1:0]  r_rsp_sum;
  logic               r_rsp_cout;

  logic [NREQ-1:0]    w_grant;
  logic [ID_W-1:0]    w_gid;
  logic               w_any;
  logic [DATA_W-1:0]  w_op1 [NREQ];
  logic [DATA_W-1:0]  w_op2 [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op1[gi] = req_op1[gi*DATA_W +: DATA_W];
    assign w_op2[gi] = req_op2[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_gid),
    .o_any   (w_any)
  );

  // Accept strobe is qualified by reset too, so no requester sees a grant while held in reset.
  assign req_ready = (r_state == ST_IDLE && !reset) ? w_grant : '0;
  assign busy      = (r_state != ST_IDLE);
  assign add_op1   = r_add_op1;
  assign add_op2   = r_add_op2;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_cnt       <= '0;
      r_add_op1   <= '0;
      r_add_op2   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_add_op1 <= w_op1[w_gid];
            r_add_op2 <= w_op2[w_gid];
            r_gid     <= w_gid;
            r_cnt     <= CNT_W'(ADD_LAT);
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rsp_sum   <= add_sum;
            r_rsp_cout  <= add_cout;
            r_rsp_id    <= r_gid;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= ID_W'(wrap_inc(int'(r_gid), NREQ));
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca64_share_ctrl.sv
// Self-checking bench for rca64_share_ctrl with a registered (1-cycle) adder model
// and a response scoreboard fed at each grant.
module tb_rca64_share_ctrl;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 64;
  localparam int ADD_LAT = 1;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] sum;
    logic              cout;
  } exp_t;

  logic                   clock;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_op1;
  logic [NREQ*DATA_W-1:0] req_op2;
  logic [NREQ-1:0]        req_ready;
  logic [DATA_W-1:0]      add_op1;
  logic [DATA_W-1:0]      add_op2;
  logic [DATA_W-1:0]      add_sum;
  logic                   add_cout;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_sum;
  logic                   rsp_cout;
  logic                   busy;

  logic [DATA_W-1:0] op1_a [NREQ];
  logic [DATA_W-1:0] op2_a [NREQ];
  logic [DATA_W:0]   r_add;
  exp_t              sb[$];
  int                total;
  int                bad;
  int                model_ptr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_op1[gi*DATA_W +: DATA_W] = op1_a[gi];
    assign req_op2[gi*DATA_W +: DATA_W] = op2_a[gi];
  end

  rca64_share_ctrl #(
    .NREQ(NREQ), .ID_W(ID_W), .DATA_W(DATA_W), .ADD_LAT(ADD_LAT)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op1(req_op1),
    .req_op2(req_op2), .req_ready(req_ready), .add_op1(add_op1), .add_op2(add_op2),
    .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle registered adder standing in for the shared RCA64 instance.
  always @(posedge clock) r_add <= {1'b0, add_op1} + {1'b0, add_op2};
  assign add_sum  = r_add[DATA_W-1:0];
  assign add_cout = r_add[DATA_W];

  // Response monitor: pops the scoreboard on each handshake and advances the pointer model.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got id=%0d sum=%h", rsp_id, rsp_sum);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_cout !== e.cout) begin
          bad++;
          $display("FAIL rsp_data got id=%0d sum=%h cout=%b exp id=%0d sum=%h cout=%b",
                   rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
        end
        model_ptr = (int'(e.id) + 1) % NREQ;
      end
    end
  end

  function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input int p);
    logic [ID_W-1:0] ix;
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      ix = ID_W'((p + k) % NREQ);
      if (v[ix] && oh == '0) oh[ix] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] g);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    return oh;
  endfunction

  task automatic push_exp(input logic [ID_W-1:0] g);
    logic [DATA_W:0] full;
    exp_t e;
    full   = {1'b0, op1_a[g]} + {1'b0, op2_a[g]};
    e.id   = g;
    e.sum  = full[DATA_W-1:0];
    e.cout = full[DATA_W];
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout got pending=%0d exp pending=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = '0; op2_a[i] = '0;
    end
    repeat (2) @(posedge clock); #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++;
    if (add_op1 !== '0 || add_op2 !== '0) begin
      bad++; $display("FAIL reset_add_ops got=%h/%h exp=0/0", add_op1, add_op2);
    end
    total++;
    if (rsp_id !== '0 || rsp_sum !== '0 || rsp_cout !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got id=%0d sum=%h cout=%b exp 0", rsp_id, rsp_sum, rsp_cout);
    end
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int edges;
    op1_a[0] = 64'h0000_0000_1234_5678;
    op2_a[0] = 64'h0000_0000_90ab_cdef;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL basic_grant got=%b exp=0001", req_ready); end
    push_exp(2'd0);
    @(posedge clock); #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL basic_ready_one_cycle got=%b exp=0", req_ready); end
    total++;
    if (add_op1 !== 64'h0000_0000_1234_5678 || add_op2 !== 64'h0000_0000_90ab_cdef) begin
      bad++; $display("FAIL basic_add_ops got=%h/%h", add_op1, add_op2);
    end
    req_valid = '0;
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 20) begin
      @(posedge clock); #1;
      edges++;
    end
    total++;
    if (edges !== ADD_LAT + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", edges, ADD_LAT + 1); end
    total++;
    if (rsp_sum !== 64'h0000_0000_a2e0_2467 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      bad++; $display("FAIL basic_rsp got sum=%h cout=%b id=%0d exp sum=a2e02467 cout=0 id=0",
                      rsp_sum, rsp_cout, rsp_id);
    end
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL basic_idle got busy=%b rsp_valid=%b exp 0/0", busy, rsp_valid);
    end
    total++;
    if (add_op1 !== 64'h0000_0000_1234_5678) begin
      bad++; $display("FAIL basic_ops_held got=%h exp=12345678", add_op1);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [NREQ-1:0] exp_oh;
    op1_a[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    op2_a[3] = 64'h1;
    req_valid = 4'b1000;
    #1;
    exp_oh = exp_grant(req_valid, model_ptr);
    total++;
    if (req_ready !== exp_oh) begin bad++; $display("FAIL ovf_grant got=%b exp=%b", req_ready, exp_oh); end
    push_exp(2'd3);
    @(posedge clock); #1;
    req_valid = '0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    total++;
    if (rsp_sum !== '0 || rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin
      bad++; $display("FAIL ovf_rsp got sum=%h cout=%b id=%0d exp sum=0 cout=1 id=3", rsp_sum, rsp_cout, rsp_id);
    end
    drain("ovf");
  endtask

  task automatic test_back_to_back();
    logic [ID_W-1:0] rr_order [5];
    int cyc;
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = {$urandom, $urandom};
      op2_a[i] = {$urandom, $urandom};
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    for (int t = 0; t < 5; t++) begin
      cyc = 0;
      while (req_ready === '0 && cyc < 20) begin
        @(posedge clock); #1;
        cyc++;
      end
      total++;
      if (req_ready !== onehot(rr_order[t])) begin
        bad++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, req_ready, onehot(rr_order[t]));
      end
      push_exp(rr_order[t]);
      @(posedge clock); #1;
    end
    req_valid = '0;
    drain("rr");
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [NREQ-1:0] exp_oh;
    op1_a[2] = 64'h8000_0000_0000_0001;
    op2_a[2] = 64'h8000_0000_0000_0002;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    exp_oh = exp_grant(req_valid, model_ptr);
    total++;
    if (req_ready !== exp_oh) begin bad++; $display("FAIL bp_grant got=%b exp=%b", req_ready, exp_oh); end
    push_exp(2'd2);
    @(posedge clock); #1;
    req_valid = 4'b0001;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 64'h3 || rsp_cout !== 1'b1 || rsp_id !== 2'd2 ||
          req_ready !== '0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold c=%0d got v=%b sum=%h cout=%b id=%0d rdy=%b busy=%b exp 1/3/1/2/0/1",
                        c, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, busy);
      end
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL bp_no_grant_in_handshake got=%b exp=0", req_ready); end
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got busy=%b rsp_valid=%b exp 0/0", busy, rsp_valid);
    end
    exp_oh = exp_grant(req_valid, model_ptr);
    total++;
    if (req_ready !== exp_oh) begin bad++; $display("FAIL bp_next_grant got=%b exp=%b", req_ready, exp_oh); end
    push_exp(2'd0);
    @(posedge clock); #1;
    req_valid = '0;
    drain("bp");
  endtask

  task automatic test_reset_busy();
    logic [NREQ-1:0] exp_oh;
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    #1;
    exp_oh = exp_grant(req_valid, model_ptr);
    total++;
    if (req_ready !== exp_oh) begin bad++; $display("FAIL rb_grant got=%b exp=%b", req_ready, exp_oh); end
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0 || add_op1 !== '0 || add_op2 !== '0 ||
        rsp_sum !== '0 || rsp_id !== '0 || rsp_cout !== 1'b0) begin
      bad++; $display("FAIL rb_async_clear got busy=%b v=%b rdy=%b op1=%h op2=%h exp all 0",
                      busy, rsp_valid, req_ready, add_op1, add_op2);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rb_no_rsp got=%b exp=0", rsp_valid); end
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL rb_ptr_reset got=%b exp=0001", req_ready); end
    push_exp(2'd0);
    @(posedge clock); #1;
    req_valid = '0;
    drain("rb");
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] vtab [3];
    logic [ID_W-1:0] gtab [3];
    int cyc;
    vtab = '{4'b0100, 4'b0100, 4'b1111};
    gtab = '{2'd2, 2'd2, 2'd3};
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req_valid = vtab[t];
      #1;
      cyc = 0;
      while (req_ready === '0 && cyc < 20) begin
        @(posedge clock); #1;
        cyc++;
      end
      total++;
      if (req_ready !== onehot(gtab[t])) begin
        bad++; $display("FAIL wrap_grant t=%0d got=%b exp=%b", t, req_ready, onehot(gtab[t]));
      end
      push_exp(gtab[t]);
      @(posedge clock); #1;
      req_valid = '0;
      drain("wrap");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_ptr = 0;
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_busy();
    test_wrap();
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL end_state got pending=%0d rsp_valid=%b exp 0/0", sb.size(), rsp_valid);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timed out");
  end

endmodule
